// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM and hands words to
// decode through a one-entry valid/ready buffer. Stops on WFI until redirected.
module instr_fetch #(
  parameter int          L        = 32,
  parameter int          AW       = $clog2(L),
  parameter logic [31:0] WFI_WORD = 32'h10500073
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic [AW-1:0] rom_addr,
  output logic          rom_oe,
  input  logic [31:0]   rom_data,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic [31:0]   instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          halted
);
  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0]   word;
    logic [AW-1:0] pc;
  } ibuf_t;

  state_t        state, state_nx;
  ibuf_t         ib;
  logic [AW-1:0] pc, pc_inc, tgt;
  logic          load, is_wfi;

  // Branch owns the cycle: no ROM read, so a redirect always costs one bubble.
  assign load     = (state == RUN) && !branch_taken && (!instr_valid || instr_ready);
  assign rom_oe   = load && reset_n;
  assign rom_addr = pc;
  assign is_wfi   = (rom_data == WFI_WORD);

  // Explicit wrap and range mask keep non-power-of-two depths correct.
  assign pc_inc = (pc == AW'(L - 1)) ? '0 : pc + 1'b1;
  assign tgt    = ({1'b0, branch_target} >= (AW+1)'(L)) ? '0 : branch_target;

  assign instr    = ib.word;
  assign instr_pc = ib.pc;
  assign halted   = (state == HALT);

  always_comb begin
    state_nx = state;
    if (branch_taken)          state_nx = RUN;
    else if (load && is_wfi)   state_nx = HALT;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      ib          <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= tgt;
      instr_valid <= 1'b0;
    end else if (load) begin
      ib          <= '{word: rom_data, pc: pc};
      instr_valid <= 1'b1;
      if (!is_wfi) pc <= pc_inc;
    end else if (instr_ready) begin
      // Only reachable when halted: the drained buffer goes empty.
      instr_valid <= 1'b0;
    end
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that sits directly upstream of the instruction ROM.
- Holds the program counter and drives the ROM word address and output enable.
- Registers each fetched 32-bit word into a one-entry output buffer, with a valid/ready handshake to decode.
- Handles branch redirects from execute, and halts on a `wfi` word (32'h10500073).

Parameters:
- L, 32, ROM depth in words; must match the instruction ROM's depth.
- AW, $clog2(L), word-address width for PC, ROM address and branch target.
- WFI_WORD, 32'h10500073, encoding that halts fetch.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- rom_addr, output, AW, word address to the ROM; equals the current pc (combinational).
- rom_oe, output, 1, ROM output enable; high only in a cycle that loads the buffer.
- rom_data, input, 32, combinational ROM read data; valid in the same cycle as rom_oe.
- branch_taken, input, 1, redirect request from execute.
- branch_target, input, AW, word address to redirect to.
- instr, output, 32, buffered instruction.
- instr_pc, output, AW, word address of the buffered instruction.
- instr_valid, output, 1, buffer holds an instruction for decode.
- instr_ready, input, 1, decode accepts instr this cycle.
- halted, output, 1, fetch stopped on WFI_WORD.

Behaviour:
- **Reset.** reset_n low clears immediately, independent of clock:
  - pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0, state=RUN.
  - rom_oe=0 while reset_n is low.
  - This holds for reset mid-operation: the buffered instruction and the halt state are discarded.
- **States.** Two states: RUN and HALT.
- **Load condition.** load = (state==RUN) && !branch_taken && (!instr_valid || instr_ready).
  - rom_oe = load.
  - rom_addr = pc at all times.
- **On load (rising edge):**
  - instr<=rom_data, instr_pc<=pc, instr_valid<=1.
  - If rom_data==WFI_WORD: state<=HALT, halted<=1, pc held. The WFI word is still delivered to decode.
  - Otherwise: pc<=pc+1, with pc==L-1 wrapping to 0. Wrap is explicit, so non-power-of-two L is also correct.
- **Latency.** The word at pc is visible on instr one clock after the edge where load is high. With instr_ready held high, throughput is one instruction per clock.
- **Handshake.**
  - A transfer occurs when instr_valid && instr_ready.
  - With instr_valid=1 and instr_ready=0: instr, instr_pc and pc are held, and rom_oe=0.
  - When a transfer occurs without a new load (HALT): instr_valid<=0.
  - A transfer and a load in the same cycle replace the buffer contents without a bubble.
- **Redirect.** branch_taken has priority over load and handshake:
  - pc<=branch_target, instr_valid<=0 (buffered instruction flushed), no ROM access that cycle.
  - From HALT, it also sets state<=RUN and halted<=0.
  - The first instruction from the target appears two edges after the redirect edge.
- **HALT.**
  - rom_oe=0 and pc frozen at the WFI address.
  - The buffered WFI is still drained through the handshake.
  - Only branch_taken or reset leaves HALT.
- **Out of range.** A branch_target >= L, for non-power-of-two L, is masked to 0.

Test Plan:
1. ROM word 0=32'h000000B3, word 1=32'h00700123; reset release, instr_ready=1 → first edge: instr=32'h000000B3, instr_pc=0, instr_valid=1; next edge: instr=32'h00700123, instr_pc=1; rom_oe=1 every cycle.
2. After the first valid, instr_ready=0 for 3 cycles → instr/instr_pc frozen at word 0/0, rom_oe=0, rom_addr=1; ready back to 1 → next edge instr_pc=1, with no word skipped or duplicated.
3. While instr_pc=2 is valid, pulse branch_taken with branch_target=5 → next edge instr_valid=0, rom_addr=5; following edge instr_pc=5, instr=ROM[5].
4. ROM word 8=32'h10500073 → instr_pc=8 delivered with halted=1, then rom_oe=0 and rom_addr stays 8. After the ready transfer, instr_valid=0. branch_taken with target 0 → halted=0, and fetch restarts at 0.
5. L=32, ROM filled with no WFI, instr_ready=1 → instr_pc sequence 30, 31, 0, 1 with no gap.
6. Assert reset_n low mid-cycle while instr_valid=1 and pc=6 → instr_valid, instr, instr_pc, halted and rom_oe drop to 0 before the next edge. On release, fetch resumes at address 0.
